// File: rtl/mod_seq.sv
// Sequential restoring divider: R = Y mod X (and Q = Y / X), one quotient bit per clock.
// Define MOD_SEQ_QUOTIENT_EN to build the quotient register; otherwise Q is tied to 0.
module mod_seq #(
    parameter int unsigned WIDTH = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] R,
    output logic [WIDTH-1:0] Q,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int unsigned CNTW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StIter, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] xr_q, xr_d;
    logic [WIDTH-1:0] yr_q, yr_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             err_q, err_d;

    // Trial value carries one extra bit so a partial remainder >= 2^(WIDTH-1) is not lost.
    logic [WIDTH:0]   trial;
    logic             ge;
    logic [WIDTH-1:0] step_rem;

    always_comb begin
        trial    = {rem_q, yr_q[WIDTH-1]};
        ge       = (trial >= {1'b0, xr_q});
        // Difference is below xr, so the low WIDTH bits are exact.
        step_rem = ge ? (trial[WIDTH-1:0] - xr_q) : trial[WIDTH-1:0];
    end

    always_comb begin
        state_d = state_q;
        xr_d    = xr_q;
        yr_d    = yr_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                if (go) begin
                    xr_d  = X;
                    yr_d  = Y;
                    rem_d = '0;
                    cnt_d = CNTW'(WIDTH - 1);
                    if (X == '0) begin
                        rem_d   = Y;
                        r_d     = Y;
                        err_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        state_d = StIter;
                    end
                end
            end
            StIter: begin
                if (!go) begin
                    rem_d   = '0;
                    state_d = StIdle;
                end else begin
                    rem_d = step_rem;
                    yr_d  = yr_q << 1;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        r_d     = step_rem;
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (!go) begin
                    r_d     = '0;
                    err_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            xr_q    <= '0;
            yr_q    <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            r_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            xr_q    <= xr_d;
            yr_q    <= yr_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            err_q   <= err_d;
        end
    end

`ifdef MOD_SEQ_QUOTIENT_EN
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] qo_q, qo_d;

    always_comb begin
        quo_d = quo_q;
        qo_d  = qo_q;
        case (state_q)
            StIdle: begin
                if (go) begin
                    quo_d = (X == '0) ? '1 : '0;
                    if (X == '0) qo_d = '1;
                end
            end
            StIter: begin
                if (!go) begin
                    quo_d = '0;
                end else begin
                    quo_d = {quo_q[WIDTH-2:0], ge};
                    if (cnt_q == '0) qo_d = {quo_q[WIDTH-2:0], ge};
                end
            end
            StDone: begin
                if (!go) qo_d = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            quo_q <= '0;
            qo_q  <= '0;
        end else begin
            quo_q <= quo_d;
            qo_q  <= qo_d;
        end
    end

    assign Q = qo_q;
`else
    assign Q = '0;
`endif

    assign R    = r_q;
    assign err  = err_q;
    assign busy = (state_q == StIter);
    assign done = (state_q == StDone);

endmodule

// File: tb/tb_mod_seq.sv
// Directed self-checking bench for mod_seq (WIDTH=9); expected Q follows MOD_SEQ_QUOTIENT_EN.
module tb_mod_seq;

    localparam int unsigned WIDTH = 9;
`ifdef MOD_SEQ_QUOTIENT_EN
    localparam bit QEN = 1'b1;
`else
    localparam bit QEN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             go;
    logic [WIDTH-1:0] X, Y;
    logic [WIDTH-1:0] R, Q;
    logic             busy, done, err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mod_seq #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .reset(reset),
        .go   (go),
        .X    (X),
        .Y    (Y),
        .R    (R),
        .Q    (Q),
        .busy (busy),
        .done (done),
        .err  (err)
    );

    function automatic logic [WIDTH-1:0] exp_q(input logic [WIDTH-1:0] q);
        return QEN ? q : '0;
    endfunction

    // Raises go with operands, then steps edges 0..WIDTH watching busy/done.
    task automatic run_op(input logic [WIDTH-1:0] y, input logic [WIDTH-1:0] x,
                          input string name);
        @(negedge clk);
        go = 1'b1;
        Y  = y;
        X  = x;
        for (int e = 0; e < WIDTH; e++) begin
            @(posedge clk);
            #1;
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL %s edge%0d busy/done: got %b/%b want 1/0", name, e, busy, done);
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL %s completion busy/done: got %b/%b want 0/1", name, busy, done);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        go    = 1'b0;
        X     = '0;
        Y     = '0;
        #1;
        checks++;
        if ({R, Q, busy, done, err} !== '0) begin
            errors++;
            $display("FAIL reset outputs: got R=%0d Q=%0d b=%b d=%b e=%b want all 0",
                     R, Q, busy, done, err);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_divide();
        logic [WIDTH-1:0] vy[4] = '{9'd100, 9'd5, 9'd511, 9'd511};
        logic [WIDTH-1:0] vx[4] = '{9'd7,   9'd9, 9'd1,   9'd256};
        logic [WIDTH-1:0] vr[4] = '{9'd2,   9'd5, 9'd0,   9'd255};
        logic [WIDTH-1:0] vq[4] = '{9'd14,  9'd0, 9'd511, 9'd1};
        for (int i = 0; i < 4; i++) begin
            run_op(vy[i], vx[i], "divide");
            checks++;
            if (R !== vr[i] || Q !== exp_q(vq[i]) || err !== 1'b0) begin
                errors++;
                $display("FAIL divide %0d/%0d: got R=%0d Q=%0d err=%b want R=%0d Q=%0d err=0",
                         vy[i], vx[i], R, Q, err, vr[i], exp_q(vq[i]));
            end
            @(negedge clk);
            go = 1'b0;
            @(posedge clk);
            #1;
            checks++;
            if (done !== 1'b0 || R !== '0 || Q !== '0) begin
                errors++;
                $display("FAIL divide release: got done=%b R=%0d Q=%0d want 0/0/0", done, R, Q);
            end
        end
    endtask

    task automatic test_div_zero();
        @(negedge clk);
        go = 1'b1;
        Y  = 9'd77;
        X  = 9'd0;
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b1 || err !== 1'b1 || busy !== 1'b0 || R !== 9'd77
            || Q !== exp_q(9'd511)) begin
            errors++;
            $display("FAIL div_zero: got d=%b e=%b b=%b R=%0d Q=%0d want 1/1/0 R=77 Q=%0d",
                     done, err, busy, R, Q, exp_q(9'd511));
        end
        @(negedge clk);
        go = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || err !== 1'b0 || R !== '0) begin
            errors++;
            $display("FAIL div_zero release: got d=%b e=%b R=%0d want 0/0/0", done, err, R);
        end
    endtask

    task automatic test_abort();
        @(negedge clk);
        go = 1'b1;
        Y  = 9'd300;
        X  = 9'd17;
        repeat (5) @(posedge clk);
        @(negedge clk);
        go = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL abort cycle%0d busy/done: got %b/%b want 0/0", c, busy, done);
            end
        end
        run_op(9'd300, 9'd17, "after_abort");
        checks++;
        if (R !== 9'd11 || Q !== exp_q(9'd17)) begin
            errors++;
            $display("FAIL after_abort: got R=%0d Q=%0d want R=11 Q=%0d", R, Q, exp_q(9'd17));
        end
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        go = 1'b1;
        Y  = 9'd123;
        X  = 9'd5;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if ({R, Q, busy, done, err} !== '0) begin
            errors++;
            $display("FAIL reset_mid: got R=%0d Q=%0d b=%b d=%b e=%b want all 0",
                     R, Q, busy, done, err);
        end
        @(negedge clk);
        go = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        run_op(9'd255, 9'd16, "post_reset");
        checks++;
        if (R !== 9'd15 || Q !== exp_q(9'd15) || err !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: got R=%0d Q=%0d err=%b want R=15 Q=%0d err=0",
                     R, Q, err, exp_q(9'd15));
        end
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic test_hold();
        run_op(9'd100, 9'd7, "hold");
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            X = 9'(c * 37 + 3);
            Y = 9'(c * 91 + 11);
            @(posedge clk);
            #1;
            checks++;
            if (done !== 1'b1 || R !== 9'd2 || Q !== exp_q(9'd14)) begin
                errors++;
                $display("FAIL hold cycle%0d: got d=%b R=%0d Q=%0d want 1 R=2 Q=%0d",
                         c, done, R, Q, exp_q(9'd14));
            end
        end
        @(negedge clk);
        go = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || R !== '0) begin
            errors++;
            $display("FAIL hold release: got d=%b R=%0d want 0/0", done, R);
        end
    endtask

    initial begin
        test_reset();
        test_divide();
        test_div_zero();
        test_abort();
        test_reset_mid();
        test_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mod_seq.md
# mod_seq

Parametrised sequential modulo/divide unit for the RSA datapath: computes R = Y mod X (and optionally Q = Y / X) for unsigned WIDTH-bit operands by radix-2 restoring shift-subtract, one quotient bit per clock. Fixed, data-independent latency; level-sensitive go/done handshake identical in spirit to the existing modular-reduction stage, plus a busy flag, a divide-by-zero flag and an abort path. It sits under the modular-exponentiation controller, which issues one reduction at a time.

## Interface
- WIDTH, 9, operand/result width in bits (≥2)
- CNTW, $clog2(WIDTH), iteration counter width (derived, not overridden)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- go  in  1  level request; held high for the whole operation and until done is seen
- X  in  WIDTH  divisor/modulus, sampled only on the accepting edge
- Y  in  WIDTH  dividend, sampled only on the accepting edge
- R  out  WIDTH  remainder, valid while done=1
- Q  out  WIDTH  quotient, valid while done=1 (see Configuration)
- busy  out  1  high in ITER
- done  out  1  high in DONE
- err  out  1  divide-by-zero, valid while done=1

## Operation
- States: IDLE, ITER, DONE (one-hot or binary, implementer's choice).
- Reset (async): state=IDLE; R, Q, busy, done, err, remainder/quotient/count regs = 0.
- IDLE: on edge with go=1: latch X→xr, Y→yr (shift reg), rem=0, q=0, cnt=WIDTH-1.
  - if X==0: go to DONE with rem=Y, q=all ones, err=1.
  - else: go to ITER.
- ITER, each edge: t = {rem, yr[MSB]} (WIDTH+1 bits); yr <<= 1; if t ≥ {0,xr}: rem = t − xr, q = {q,1}; else rem = t[WIDTH-1:0], q = {q,0}. cnt decrements; on cnt==0 edge go to DONE.
- Remainder arithmetic carried at WIDTH+1 bits so no bit is lost when rem ≥ 2^(WIDTH-1); result always < X.
- DONE: R=rem, Q=q, done=1, err as set; held stable while go=1. go=0 → IDLE, outputs R/Q/err cleared to 0 on that edge.
- Abort: go=0 on any edge in ITER → IDLE next edge; done never asserts for that request; partial results discarded.
- go held high after DONE→IDLE is impossible (DONE only exits on go=0); controller must drop go for ≥1 cycle between requests.
- X/Y changes after acceptance have no effect.

## Timing
- Accepting edge = edge 0 (IDLE, go=1). busy=1 from edge 0 through edge WIDTH−1.
- Normal: done=1 after edge WIDTH (WIDTH+1 cycles from go first sampled high incl. accept); busy falls same edge.
- X==0: done=1, err=1 after edge 0; busy never asserts.
- done/busy/R/Q/err are registered outputs; no combinational path from inputs.
- go=0 while in DONE: done=0 after next edge; IDLE can accept again on the following edge.
- Async reset mid-operation: all outputs 0 immediately, no completion generated.

## Configuration
- MOD_SEQ_QUOTIENT_EN defined: quotient shift register built, Q driven as above (X==0 → all ones).
- Not defined: quotient register removed, Q tied to 0; remainder, timing and err unchanged.

## Test plan
- WIDTH=9, Y=100, X=7, go held → busy edges 0–8, done=1 after edge 9, R=2, Q=14, err=0.
- Y=5, X=9 (Y<X) → R=5, Q=0 after edge 9; Y=511, X=1 → R=0, Q=511; Y=511, X=256 → R=255, Q=1 (WIDTH+1 carry path).
- X=0, Y=77 → done and err=1 after edge 0, R=77, Q=511 (macro on) / Q=0 (macro off), busy never high.
- Y=300, X=17, drop go after edge 4 → IDLE next edge, done stays 0; then go with Y=300, X=17 → R=11, Q=17.
- Assert reset in ITER at edge 3 → all outputs 0 asynchronously; release, run Y=255, X=16 → R=15, Q=15.
- Hold go in DONE for 20 cycles while toggling X/Y → R/Q/done unchanged; drop go → done=0 next edge.
